// File: rtl/axi_chan_slice.sv
// Multi-channel valid/ready register slice for AXI channel timing closure.
// Each lane is independently a bypass, a forward register or a full skid buffer.
module axi_chan_slice #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 128,
  parameter logic [2*NUM_CH-1:0] MODE = {NUM_CH{2'd2}}
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic [NUM_CH-1:0]        busy
);

  if (NUM_CH < 1 || DATA_W < 1) begin : g_bad_param
    $error("axi_chan_slice: NUM_CH and DATA_W must be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [1:0] CM = MODE[2*i+1:2*i];

    logic [DATA_W-1:0] sd;
    assign sd = s_data[i*DATA_W +: DATA_W];

    if (CM == 2'd0) begin : g_byp
      assign m_valid[i] = s_valid[i];
      assign s_ready[i] = m_ready[i];
      assign m_data[i*DATA_W +: DATA_W] = sd;
      assign busy[i] = 1'b0;

    end else if (CM == 2'd1) begin : g_fwd
      logic              vld;
      logic [DATA_W-1:0] dat;
      logic              ld;

      // the single slot can take a new beat when empty or draining
      assign ld = ~vld | m_ready[i];

      // output slot: valid follows upstream whenever the slot advances
      always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
          vld <= 1'b0;
        end else if (ld) begin
          vld <= s_valid[i];
          if (s_valid[i]) dat <= sd;
        end
      end

      assign s_ready[i] = ~axi_areset & ld;
      assign m_valid[i] = vld;
      assign m_data[i*DATA_W +: DATA_W] = dat;
      assign busy[i] = vld;

    end else begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } st_t;

      st_t               st;
      logic              vld;
      logic              rdy;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic              sx;
      logic              mx;

      assign sx = s_valid[i] & rdy;
      assign mx = vld & m_ready[i];

      // occupancy FSM; ready and valid are registered so no m_ready->s_ready path
      always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
          st  <= EMPTY;
          vld <= 1'b0;
          rdy <= 1'b0;
        end else begin
          unique case (st)
            EMPTY: begin
              rdy <= 1'b1;
              if (sx) begin
                st     <= ONE;
                vld    <= 1'b1;
                main_q <= sd;
              end
            end
            ONE: begin
              if (sx & mx) begin
                main_q <= sd;
              end else if (mx) begin
                st  <= EMPTY;
                vld <= 1'b0;
              end else if (sx) begin
                st     <= TWO;
                rdy    <= 1'b0;
                skid_q <= sd;
              end
            end
            TWO: begin
              if (mx) begin
                st     <= ONE;
                rdy    <= 1'b1;
                main_q <= skid_q;
              end
            end
            default: begin
              st  <= EMPTY;
              vld <= 1'b0;
              rdy <= 1'b1;
            end
          endcase
        end
      end

      assign s_ready[i] = rdy;
      assign m_valid[i] = vld;
      assign m_data[i*DATA_W +: DATA_W] = main_q;
      assign busy[i] = (st != EMPTY);
    end
  end

endmodule

// File: tb/tb_axi_chan_slice.sv
// Bench for axi_chan_slice: occupancy/queue reference model checked every cycle,
// plus directed vectors with literal expectations on a mixed-mode instance.
module tb_axi_chan_slice;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam logic [2*NCH-1:0] MODE_P = {2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    s_valid;
  logic [NCH-1:0]    s_ready;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    m_valid;
  logic [NCH-1:0]    m_ready;
  logic [NCH*DW-1:0] m_data;
  logic [NCH-1:0]    busy;

  int nvec = 0;
  int nerr = 0;

  axi_chan_slice #(
    .NUM_CH(NCH),
    .DATA_W(DW),
    .MODE(MODE_P)
  ) dut (
    .axi_aclk(clk),
    .axi_areset(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mode_of(int i);
    int m;
    m = int'((MODE_P >> (2*i)) & 2'd3);
    return (m == 3) ? 2 : m;
  endfunction

  function automatic logic [DW-1:0] md(int i);
    return m_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] sdat(int i);
    return s_data[i*DW +: DW];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // reference model: per lane FIFO of accepted, undelivered beats
  logic [DW-1:0] q [NCH][$];
  bit            lrst [NCH];

  initial for (int i = 0; i < NCH; i++) lrst[i] = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      automatic int m = mode_of(i);
      automatic bit ev;
      automatic bit esr;
      automatic bit sx;
      automatic bit mx;
      if (m == 0) begin
        chk($sformatf("byp_mvalid%0d", i), 32'(m_valid[i]), 32'(s_valid[i]));
        chk($sformatf("byp_sready%0d", i), 32'(s_ready[i]), 32'(m_ready[i]));
        chk($sformatf("byp_busy%0d", i), 32'(busy[i]), 32'd0);
        if (s_valid[i])
          chk($sformatf("byp_data%0d", i), 32'(md(i)), 32'(sdat(i)));
      end else begin
        ev = q[i].size() > 0;
        if (m == 1) esr = !rst && (!ev || m_ready[i]);
        else esr = !lrst[i] && q[i].size() < 2;
        chk($sformatf("mvalid%0d", i), 32'(m_valid[i]), 32'(ev));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(ev));
        chk($sformatf("sready%0d", i), 32'(s_ready[i]), 32'(esr));
        if (ev) chk($sformatf("data%0d", i), 32'(md(i)), 32'(q[i][0]));
        if (rst) begin
          q[i].delete();
          lrst[i] = 1'b1;
        end else begin
          mx = ev && m_ready[i];
          sx = s_valid[i] && esr;
          if (mx) void'(q[i].pop_front());
          if (sx) q[i].push_back(sdat(i));
          lrst[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      tick();
      s_valid = '0;
      m_ready = '1;
    end
  endtask

  task automatic put(int i, logic [DW-1:0] v);
    s_data[i*DW +: DW] = v;
  endtask

  int dcnt;
  int cyc;

  initial begin
    rst = 1'b1;
    s_valid = '0;
    m_ready = '1;
    s_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mvalid", 32'(m_valid & 5'b11011), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready_skid", 32'({s_ready[3], s_ready[0]}), 32'd0);
    idle(2);

    // bypass lane: zero latency, ready passes straight back
    tick();
    s_valid[2] = 1'b1;
    put(2, 16'h00A5);
    m_ready[2] = 1'b0;
    @(negedge clk);
    chk("t1_mvalid", 32'(m_valid[2]), 32'd1);
    chk("t1_mdata", 32'(md(2)), 32'h00A5);
    chk("t1_sready", 32'(s_ready[2]), 32'd0);
    chk("t1_busy", 32'(busy[2]), 32'd0);
    idle(2);

    // forward-register lane: 8 back-to-back beats, 1-cycle latency
    for (int k = 1; k <= 8; k++) begin
      tick();
      s_valid[1] = 1'b1;
      put(1, 16'(k));
      @(negedge clk);
      chk("t2_sready", 32'(s_ready[1]), 32'd1);
      if (k > 1) begin
        chk("t2_mvalid", 32'(m_valid[1]), 32'd1);
        chk("t2_mdata", 32'(md(1)), 32'(k - 1));
      end
    end
    tick();
    s_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_last", 32'(md(1)), 32'd8);
    idle(2);

    // skid lane: fill to two with output stalled, then drain in order
    tick();
    m_ready[0] = 1'b0;
    s_valid[0] = 1'b1;
    put(0, 16'h0010);
    @(negedge clk);
    chk("t3_sr0", 32'(s_ready[0]), 32'd1);
    tick();
    put(0, 16'h0011);
    @(negedge clk);
    chk("t3_sr1", 32'(s_ready[0]), 32'd1);
    chk("t3_d10a", 32'(md(0)), 32'h0010);
    tick();
    put(0, 16'h0012);
    @(negedge clk);
    chk("t3_full", 32'(s_ready[0]), 32'd0);
    chk("t3_d10b", 32'(md(0)), 32'h0010);
    tick();
    m_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_nocomb", 32'(s_ready[0]), 32'd0);
    chk("t3_d10c", 32'(md(0)), 32'h0010);
    tick();
    @(negedge clk);
    chk("t3_d11", 32'(md(0)), 32'h0011);
    chk("t3_sr2", 32'(s_ready[0]), 32'd1);
    tick();
    s_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_d12", 32'(md(0)), 32'h0012);
    tick();
    @(negedge clk);
    chk("t3_empty", 32'(m_valid[0]), 32'd0);
    idle(2);

    // reset while a skid lane holds two beats
    tick();
    m_ready[3] = 1'b0;
    s_valid[3] = 1'b1;
    put(3, 16'h0021);
    tick();
    put(3, 16'h0022);
    tick();
    s_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5_two", 32'({busy[3], s_ready[3]}), 32'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid[3] = 1'b1;
    put(3, 16'h0055);
    m_ready[3] = 1'b1;
    @(negedge clk);
    chk("t5_mvalid", 32'(m_valid[3]), 32'd0);
    chk("t5_busy", 32'(busy[3]), 32'd0);
    chk("t5_sready0", 32'(s_ready[3]), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_sready1", 32'(s_ready[3]), 32'd1);
    chk("t5_still0", 32'(m_valid[3]), 32'd0);
    tick();
    s_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5_55v", 32'(m_valid[3]), 32'd1);
    chk("t5_55d", 32'(md(3)), 32'h0055);
    tick();
    @(negedge clk);
    chk("t5_alone", 32'(m_valid[3]), 32'd0);
    idle(2);

    // mixed modes: per-lane latency, bypass lane stalled
    tick();
    s_valid = '1;
    for (int i = 0; i < NCH; i++) put(i, 16'(16'h0060 + i));
    m_ready = 5'b11011;
    @(negedge clk);
    chk("t6_ch2v", 32'(m_valid[2]), 32'd1);
    chk("t6_ch2d", 32'(md(2)), 32'h0062);
    chk("t6_lat0", 32'(m_valid & 5'b11011), 32'd0);
    tick();
    s_valid = 5'b00100;
    @(negedge clk);
    chk("t6_lat1", 32'(m_valid), 32'h1F);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("t6_d%0d", i), 32'(md(i)), 32'(16'h0060 + i));
    idle(3);

    // random traffic on all lanes, model checks every cycle
    dcnt = 0;
    cyc = 0;
    while (dcnt < 10000 && cyc < 60000) begin
      tick();
      for (int i = 0; i < NCH; i++) begin
        s_valid[i] = 1'($urandom_range(0, 1));
        m_ready[i] = 1'($urandom_range(0, 1));
        put(i, 16'($urandom));
      end
      @(negedge clk);
      if (m_valid[0] && m_ready[0]) dcnt++;
      cyc++;
    end
    chk("t4_beats_done", 32'(dcnt >= 10000), 32'd1);
    idle(4);
    @(negedge clk);
    chk("t4_drained", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
